mul_seq_param: RTL and testbench
================================

Name: mul_seq_param

Overview:
- Parametrised sequential shift-add multiplier, successor to the 16-bit repeated-addition datapath/controller multiplier.
- Generalised to WIDTH-bit operands with both operands loaded in parallel.
- Adds a signed/unsigned mode, early termination on the multiplier's highest set bit, and a busy/done handshake.
- Sits as a multi-cycle arithmetic unit beside the design's datapath; the requester drives start and collects product on done.

Parameters:
- WIDTH, 16, operand width in bits; legal range 4..32.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with the operands.
- a_in  in  WIDTH  multiplicand.
- b_in  in  WIDTH  multiplier.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; product is valid from this cycle.
- product  out  2*WIDTH  result; held until the next FIX update.

Behaviour:
- Clocking and reset: one clock domain (clk). rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0, internal registers=0.
- Reset mid-operation: on the next edge, abort to IDLE with all reset values. No partial result appears on product.
- States: IDLE, CALC, FIX, DONE. Encoding is in the shared package.
- IDLE, start=1 at edge E0:
  - capture neg = signed_mode & (a_in[MSB] ^ b_in[MSB]);
  - a_reg (2*WIDTH) = zero-extended |a_in|; b_reg (WIDTH) = |b_in|;
  - absolute value is applied only when signed_mode=1;
  - acc=0, cnt=0; state goes to CALC; busy=1 from E0.
- Most-negative operand: |-(2^(WIDTH-1))| is the unsigned value 2^(WIDTH-1) with no overflow, because the datapath is unsigned.
- CALC, b_reg != 0, each edge:
  - if b_reg[0], acc += a_reg;
  - a_reg <<= 1; b_reg >>= 1; cnt++.
- CALC, b_reg == 0: state goes to FIX, with no arithmetic on that edge.
  - Early termination: work cycles k = position of the highest set bit of |b| + 1; k=0 when b=0.
  - cnt never exceeds WIDTH; reaching WIDTH forces b_reg==0.
- FIX edge: product = neg ? (~acc + 1) : acc, truncated to 2*WIDTH bits; state goes to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; next edge returns to IDLE.
- Latency: done is high in the cycle following edge E0+k+2.
  - Minimum 2 edges (b=0); maximum WIDTH+2.
  - Latency is independent of a and of signed_mode, apart from the |b| transform.
- Handshake:
  - start while busy=1, or in the DONE cycle, is ignored (no queueing).
  - start held high continuously gives back-to-back operations with one IDLE cycle between DONE and the next capture.
  - a_in, b_in and signed_mode may change freely after E0.
- Arithmetic: unsigned product is exact in 2*WIDTH bits. The signed product is exact, including (-2^(W-1))^2 = 2^(2W-2).

Decomposition:
- Package mul_seq_pkg holds the state encoding localparams (IDLE, CALC, FIX, DONE) and a MUL_MAX_WIDTH constant (32).
- Natural split, matching the existing datapath/controller style:
  - sub-module mul_seq_ctrl holds the FSM plus busy/done;
  - datapath registers and the adder stay in mul_seq_param.
- Control signals between them: ld, shift, add_en, fix_en, bz (b_reg==0).

Test Plan:
- WIDTH=16, unsigned, a=17, b=5 -> product=85. Done in the cycle after E0+5; busy high for exactly 5 cycles.
- Unsigned a=1234, b=0 -> product=0, done after E0+2. Then unsigned a=0xFFFF, b=0xFFFF -> product=0xFFFE0001, done after E0+18.
- Signed a=-3 (0xFFFD), b=7 -> product=0xFFFFFFEB, done after E0+5. Signed a=b=0x8000 -> product=0x40000000.
- Start at E0 with a=100, b=200; pulse start again at E0+3 with other operands -> second request ignored; product=20000. Then rst at E0+2 of a new op -> busy=0, done=0, product=0 next cycle; no done pulse.
- WIDTH=8, unsigned 200*3 -> product=600 (16'h0258). Signed 8'h80*8'h01 -> 16'hFF80.
- Start held high for 3 ops -> exactly 3 done pulses. Each is separated by one IDLE cycle after the DONE cycle. Products are correct per op.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding
// and the widest operand the datapath is built for.
package mul_seq_pkg;

  localparam int MUL_MAX_WIDTH = 32;
  localparam int MUL_MIN_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Controller for the shift-add multiplier: sequences load, shift/add,
// sign fix-up and the one-cycle done pulse; busy and done are registered.
module mul_seq_ctrl
  import mul_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bz,
  input  logic b_lsb,
  output logic ld,
  output logic shift,
  output logic add_en,
  output logic fix_en,
  output logic busy,
  output logic done
);

  mul_state_e state;

  // Handshake: start is honoured only in IDLE; requests seen while busy or
  // in the DONE cycle are dropped, never queued.  done pulses for exactly
  // one cycle with busy low, and product is valid from that cycle on.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          if (bz) begin
            state <= FIX;
          end
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // The edge that sees b_reg == 0 does no arithmetic, it only moves to FIX.
  assign ld     = (state == IDLE) && start;
  assign shift  = (state == CALC) && !bz;
  assign add_en = shift && b_lsb;
  assign fix_en = (state == FIX);

endmodule

// File: rtl/mul_seq_param.sv
// WIDTH-bit sequential shift-add multiplier with signed/unsigned mode and
// early termination once the remaining multiplier bits are all zero.
module mul_seq_param
  import mul_seq_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  if (WIDTH < MUL_MIN_WIDTH || WIDTH > MUL_MAX_WIDTH) begin : g_width_check
    $error("mul_seq_param: WIDTH out of supported range");
  end

  logic [2*WIDTH-1:0] a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [2*WIDTH-1:0] acc_neg;

  logic ld;
  logic shift;
  logic add_en;
  logic fix_en;
  logic bz;

  // Magnitudes are taken in an unsigned WIDTH-bit field, so the most
  // negative operand maps to 2^(WIDTH-1) without overflow.
  assign a_abs   = (signed_mode && a_in[WIDTH-1]) ? (~a_in + 1'b1) : a_in;
  assign b_abs   = (signed_mode && b_in[WIDTH-1]) ? (~b_in + 1'b1) : b_in;
  assign acc_neg = ~acc + 1'b1;
  assign bz      = (b_reg == '0);

  mul_seq_ctrl u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bz     (bz),
    .b_lsb  (b_reg[0]),
    .ld     (ld),
    .shift  (shift),
    .add_en (add_en),
    .fix_en (fix_en),
    .busy   (busy),
    .done   (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      if (ld) begin
        a_reg <= {{WIDTH{1'b0}}, a_abs};
        b_reg <= b_abs;
        acc   <= '0;
        cnt   <= '0;
        neg   <= signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
      end else if (shift) begin
        if (add_en) begin
          acc <= acc + a_reg;
        end
        a_reg <= a_reg << 1;
        b_reg <= b_reg >> 1;
        cnt   <= cnt + 1'b1;
      end
      // product only changes here, so it holds between operations and
      // never shows a partial sum.
      if (fix_en) begin
        product <= neg ? acc_neg : acc;
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_param.sv
// Directed bench for mul_seq_param at WIDTH=16 and WIDTH=8: drivers push
// expected product, done cycle and busy length; monitors pop on done.
module tb_mul_seq_param;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [31:0] prod16;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [31:0] exp16_q[$];
  int          cyc16_q[$];
  int          lat16_q[$];
  logic [15:0] exp8_q[$];
  int          cyc8_q[$];
  int          lat8_q[$];

  int          run16 = 0, run8 = 0;
  logic [31:0] e16;
  logic [15:0] e8;
  int          ec16, el16, ec8, el8;

  mul_seq_param #(.WIDTH(16)) dut16 (
    .clk (clk), .rst (rst), .start (start16), .signed_mode (sm16),
    .a_in (a16), .b_in (b16), .busy (busy16), .done (done16), .product (prod16)
  );

  mul_seq_param #(.WIDTH(8)) dut8 (
    .clk (clk), .rst (rst), .start (start8), .signed_mode (sm8),
    .a_in (a8), .b_in (b8), .busy (busy8), .done (done8), .product (prod8)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      run16 = 0;
    end else begin
      if (busy16) run16++;
      if (done16) begin
        if (exp16_q.size() == 0) begin
          check("unexpected_done16", 1, 0);
        end else begin
          e16 = exp16_q.pop_front();
          ec16 = cyc16_q.pop_front();
          el16 = lat16_q.pop_front();
          check("product16", prod16, e16);
          check("done_cycle16", cyc, ec16);
          check("busy_cycles16", run16, el16);
          check("busy_in_done16", busy16, 0);
        end
      end
      if (!busy16) run16 = 0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      run8 = 0;
    end else begin
      if (busy8) run8++;
      if (done8) begin
        if (exp8_q.size() == 0) begin
          check("unexpected_done8", 1, 0);
        end else begin
          e8 = exp8_q.pop_front();
          ec8 = cyc8_q.pop_front();
          el8 = lat8_q.pop_front();
          check("product8", prod8, e8);
          check("done_cycle8", cyc, ec8);
          check("busy_cycles8", run8, el8);
          check("busy_in_done8", busy8, 0);
        end
      end
      if (!busy8) run8 = 0;
    end
  end

  // Drivers: lat = edges from capture (E0) to the edge after which done is high.
  task automatic issue16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input int lat);
    @(negedge clk);
    sm16 = sm; a16 = a; b16 = b; start16 = 1'b1;
    @(posedge clk); #1;
    exp16_q.push_back(exp); cyc16_q.push_back(cyc + lat); lat16_q.push_back(lat);
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom_range(0, 1));
  endtask

  task automatic issue8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int lat);
    @(negedge clk);
    sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    exp8_q.push_back(exp); cyc8_q.push_back(cyc + lat); lat8_q.push_back(lat);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom_range(0, 1));
  endtask

  task automatic drain16();
    int n = 0;
    while (exp16_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp16_q.size() != 0) begin
      check("timeout16", exp16_q.size(), 0);
      exp16_q.delete(); cyc16_q.delete(); lat16_q.delete();
    end
  endtask

  task automatic drain8();
    int n = 0;
    while (exp8_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp8_q.size() != 0) begin
      check("timeout8", exp8_q.size(), 0);
      exp8_q.delete(); cyc8_q.delete(); lat8_q.delete();
    end
  endtask

  // start held high: next capture comes two edges after the done edge.
  task automatic back_to_back16();
    logic        sm_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] a_t  [3] = '{16'd3, 16'hFFFE, 16'h1000};
    logic [15:0] b_t  [3] = '{16'd3, 16'hFFFE, 16'h0100};
    logic [31:0] p_t  [3] = '{32'd9, 32'd4, 32'h0010_0000};
    int          l_t  [3] = '{4, 4, 11};
    @(negedge clk);
    sm16 = sm_t[0]; a16 = a_t[0]; b16 = b_t[0]; start16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      exp16_q.push_back(p_t[i]); cyc16_q.push_back(cyc + l_t[i]); lat16_q.push_back(l_t[i]);
      if (i < 2) begin
        sm16 = sm_t[i+1]; a16 = a_t[i+1]; b16 = b_t[i+1];
        repeat (l_t[i] + 1) @(posedge clk);
      end else begin
        start16 = 1'b0;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy16", busy16, 0);
    check("reset_done16", done16, 0);
    check("reset_product16", prod16, 0);
    check("reset_busy8", busy8, 0);
    check("reset_product8", prod8, 0);
    @(negedge clk);
    rst = 1'b0;

    issue16(1'b0, 16'd17, 16'd5, 32'd85, 5);              drain16();
    issue16(1'b0, 16'd1234, 16'd0, 32'd0, 2);             drain16();
    issue16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 18); drain16();
    issue16(1'b1, 16'hFFFD, 16'd7, 32'hFFFF_FFEB, 5);     drain16();
    issue16(1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 18); drain16();
    issue16(1'b1, 16'd5, 16'hFFFD, 32'hFFFF_FFF1, 4);     drain16();

    // Second start while busy must be ignored.
    issue16(1'b0, 16'd100, 16'd200, 32'd20000, 10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    sm16 = 1'b1; a16 = 16'd7; b16 = 16'd9; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    drain16();
    repeat (4) @(posedge clk);

    // Reset at E0+2 aborts: no done, product cleared.
    @(negedge clk);
    sm16 = 1'b0; a16 = 16'd50; b16 = 16'd255; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy16", busy16, 0);
    check("abort_done16", done16, 0);
    check("abort_product16", prod16, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_idle_busy16", busy16, 0);
    check("abort_idle_product16", prod16, 0);

    back_to_back16();
    drain16();

    issue8(1'b0, 8'd200, 8'd3, 16'h0258, 4);   drain8();
    issue8(1'b1, 8'h80, 8'h01, 16'hFF80, 3);   drain8();
    issue8(1'b1, 8'h80, 8'h80, 16'h4000, 10);  drain8();
    issue8(1'b0, 8'hFF, 8'h80, 16'h7F80, 10);  drain8();

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
